// File: rtl/scan_hist_disp.sv
// Scan-code history display: keeps the newest DIGITS/2 received bytes and
// multiplexes them as hex onto a seven-segment display. Optional macro: SCAN_BREAK_MARK_EN.
module scan_hist_disp #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 18
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             data_ready,
    input  logic [7:0]                       data,
    input  logic                             clear,
    input  logic                             freeze,
    output logic [7:0]                       sseg,
    output logic [DIGITS-1:0]                an,
    output logic [$clog2(DIGITS/2+1)-1:0]    fill
);

    localparam int BYTES  = DIGITS / 2;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int PRE_W  = REFRESH_BITS - IDX_W;
    localparam int FILL_W = $clog2(BYTES + 1);

    // Active-low hex font, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [7:0]        slot_r [BYTES];
    logic [FILL_W-1:0] fill_r;
    logic [PRE_W-1:0]  presc_r;
    logic [IDX_W-1:0]  digit_r;
    logic [DIGITS-1:0] an_r;
    logic [7:0]        sseg_r;

    logic              accept_s;
    logic              store_s;
    logic [IDX_W-1:0]  sel_slot_s;
    logic [7:0]        byte_s;
    logic [3:0]        nib_s;
    logic              visible_s;
    logic              dp_s;
    logic [DIGITS-1:0] an_s;
    logic [7:0]        sseg_s;

    assign accept_s = data_ready & ~freeze & ~clear;

`ifdef SCAN_BREAK_MARK_EN
    logic [BYTES-1:0] brk_r;
    logic             pend_r;
    logic             is_brk_s;
    logic             flag_s;

    assign is_brk_s = accept_s && (data == 8'hF0);
    assign store_s  = accept_s && !is_brk_s;

    // A break prefix is swallowed and marks the byte that follows it
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            brk_r  <= {BYTES{1'b0}};
            pend_r <= 1'b0;
        end else if (is_brk_s) begin
            pend_r <= 1'b1;
        end else if (store_s) begin
            for (int k = BYTES - 1; k >= 1; k--) begin
                brk_r[k] <= brk_r[k-1];
            end
            brk_r[0] <= pend_r;
            pend_r   <= 1'b0;
        end
    end
`else
    assign store_s = accept_s;
`endif

    // History shift register and saturating fill count
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int k = 0; k < BYTES; k++) begin
                slot_r[k] <= 8'h00;
            end
            fill_r <= {FILL_W{1'b0}};
        end else if (store_s) begin
            for (int k = BYTES - 1; k >= 1; k--) begin
                slot_r[k] <= slot_r[k-1];
            end
            slot_r[0] <= data;
            if (fill_r != FILL_W'(BYTES)) begin
                fill_r <= fill_r + FILL_W'(1);
            end
        end
    end

    // Refresh counter split as {digit, prescaler} so non-power-of-two digit counts wrap cleanly
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= {PRE_W{1'b0}};
            digit_r <= {IDX_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRE_W'(1);
            if (&presc_r) begin
                digit_r <= (digit_r == IDX_W'(DIGITS - 1)) ? {IDX_W{1'b0}} : digit_r + IDX_W'(1);
            end
        end
    end

    // Select the byte and nibble behind the current digit and encode it
    always_comb begin
        sel_slot_s = digit_r >> 1;
        byte_s     = 8'h00;
        for (int k = 0; k < BYTES; k++) begin
            byte_s = (k == int'(sel_slot_s)) ? slot_r[k] : byte_s;
        end
        nib_s     = digit_r[0] ? byte_s[7:4] : byte_s[3:0];
        visible_s = (32'(sel_slot_s) < 32'(fill_r));
`ifdef SCAN_BREAK_MARK_EN
        flag_s = 1'b0;
        for (int k = 0; k < BYTES; k++) begin
            flag_s = (k == int'(sel_slot_s)) ? brk_r[k] : flag_s;
        end
        dp_s = ~(flag_s & ~digit_r[0]);
`else
        dp_s = 1'b1;
`endif
        if (visible_s) begin
            sseg_s = {dp_s, hex7(nib_s)};
        end else begin
            sseg_s = 8'hFF;
        end
        an_s = {DIGITS{1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            an_s[i] = (i == int'(digit_r)) ? 1'b0 : 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r   <= {DIGITS{1'b1}};
            sseg_r <= 8'hFF;
        end else begin
            an_r   <= an_s;
            sseg_r <= sseg_s;
        end
    end

    assign an   = an_r;
    assign sseg = sseg_r;
    assign fill = fill_r;

endmodule

// File: tb/tb_scan_hist_disp.sv
// Scoreboard bench for scan_hist_disp (DIGITS=4, REFRESH_BITS=4): directed bytes,
// hand-computed per-digit segment codes, monitor pops expectations every cycle.
module tb_scan_hist_disp;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data       = 8'h00;
    logic       clear      = 1'b0;
    logic       freeze     = 1'b0;
    logic [7:0] sseg;
    logic [3:0] an;
    logic [1:0] fill;

    typedef struct {
        string      nm;
        logic [3:0] an;
        logic [7:0] sseg;
        logic [1:0] fill;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    logic rst_edge = 1'b1;

    always #5 clk = ~clk;

    scan_hist_disp #(.DIGITS(4), .REFRESH_BITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_ready (data_ready),
        .data       (data),
        .clear      (clear),
        .freeze     (freeze),
        .sseg       (sseg),
        .an         (an),
        .fill       (fill)
    );

    // Cycles since reset release; 4 cycles per digit, 16-cycle scan period
    always @(posedge clk) begin
        if (reset) begin
            cyc      <= 0;
            rst_edge <= 1'b1;
        end else begin
            cyc      <= cyc + 1;
            rst_edge <= 1'b0;
        end
    end

    // Monitor: compare the DUT outputs against the expectation for this edge
    always @(posedge clk) begin
        #3;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            if (an !== mon_e.an) begin
                n_bad++;
                $display("FAIL %s an: got %b want %b (t=%0t)", mon_e.nm, an, mon_e.an, $time);
            end
            n_cmp++;
            if (sseg !== mon_e.sseg) begin
                n_bad++;
                $display("FAIL %s sseg: got %h want %h (t=%0t)", mon_e.nm, sseg, mon_e.sseg, $time);
            end
            n_cmp++;
            if (fill !== mon_e.fill) begin
                n_bad++;
                $display("FAIL %s fill: got %0d want %0d (t=%0t)", mon_e.nm, fill, mon_e.fill, $time);
            end
        end
    end

    // Push n expectations; e0..e3 are the hand-computed codes for digits 0..3
    task automatic window(input int n, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3,
                          input logic [1:0] f, input string nm);
        logic [7:0] tab [4];
        logic [3:0] one_h;
        exp_t       e;
        int         d;
        tab = '{e0, e1, e2, e3};
        repeat (n) begin
            @(posedge clk);
            #1;
            e.nm = nm;
            if (rst_edge) begin
                e.an   = 4'hF;
                e.sseg = 8'hFF;
                e.fill = 2'd0;
            end else begin
                d      = ((cyc - 1) >> 2) & 3;
                one_h  = 4'b0001 << d;
                e.an   = ~one_h;
                e.sseg = tab[d];
                e.fill = f;
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic clr = 1'b0, input logic frz = 1'b0);
        @(negedge clk);
        data       = b;
        data_ready = 1'b1;
        clear      = clr;
        freeze     = frz;
        @(negedge clk);
        data_ready = 1'b0;
        clear      = 1'b0;
        freeze     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        window(2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0, "reset_state");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int t;
        do_reset();
        window(4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0, "first_after_reset");

        send(8'h1C);
        send(8'h32);
        window(16, 8'hA4, 8'hB0, 8'hC6, 8'hF9, 2'd2, "two_bytes");

        do_reset();
        send(8'hA5);
        window(16, 8'h92, 8'h88, 8'hFF, 8'hFF, 2'd1, "one_byte");

        do_reset();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        window(16, 8'hB0, 8'hB0, 8'hA4, 8'hA4, 2'd2, "overflow");

        send(8'h44, 1'b1, 1'b0);
        window(16, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0, "clear_wins");

        send(8'h5A);
        send(8'h77, 1'b0, 1'b1);
        window(16, 8'h88, 8'h92, 8'hFF, 8'hFF, 2'd1, "freeze");

        do_reset();
        send(8'hF0);
        send(8'h1C);
`ifdef SCAN_BREAK_MARK_EN
        window(16, 8'h46, 8'hF9, 8'hFF, 8'hFF, 2'd1, "break_mark");
`else
        window(16, 8'hC6, 8'hF9, 8'hC0, 8'h8E, 2'd2, "f0_plain");
`endif

        do_reset();
        send(8'h1C);
        send(8'h32);
        repeat (6) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        window(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0, "mid_reset");
        @(negedge clk);
        reset = 1'b0;
        window(4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0, "after_mid_reset");

        t = 0;
        while (sb_q.size() > 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #5;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
